gpu_draw_engine: RTL and testbench
==================================

// Module: gpu_draw_engine
// PURPOSE
// - CPU-facing draw engine for the Herring GPU. It drives the framebuffer write port (X_POS/Y_POS/COLOR/WRITE).
// - The 6502 bus side loads coordinate, size and colour registers, then writes a command.
// - The engine then emits one pixel write per PIXEL_CLOCK for: plot, fill-rectangle, clear-screen.
// PARAMETERS
// - RESOLUTION_W  200  framebuffer width in pixels
// - RESOLUTION_H  150  framebuffer height in pixels
// - COLOR_DEPTH   3    bits per pixel
// PORTS
// - PIXEL_CLOCK  in   1   single clock; all logic on posedge
// - RESET        in   1   synchronous, active-high reset
// - ADDR         in   3   register select
// - DATA_IN      in   8   register write data
// - WE           in   1   one-cycle write strobe (already synchronised to PIXEL_CLOCK)
// - DATA_OUT     out  8   register readback (combinational from ADDR)
// - X_POS        out  8   framebuffer write column
// - Y_POS        out  8   framebuffer write row
// - COLOR        out  COLOR_DEPTH  framebuffer write colour
// - WRITE        out  1   framebuffer write enable, one pixel per cycle
// - BUSY         out  1   command in progress
// BEHAVIOUR
// - Register map:
//   - 0 X; 1 Y; 2 COL (low COLOR_DEPTH bits kept); 3 W; 4 H.
//   - 5 CMD, write-only trigger: 0=PLOT, 1=FILL, 2=CLEAR, other codes ignored.
//   - Reads of 0-4 return the register value, zero-extended.
//   - Read of 5 returns {7'b0,BUSY}. Reads of 6-7 return 0.
// - Reset: all registers 0, state IDLE, WRITE=0, BUSY=0, X_POS=Y_POS=0, COLOR=0.
// - While BUSY, any WE is ignored (all addresses), so a command's operands are stable.
// - States: IDLE -> RUN -> IDLE.
//   - IDLE: a valid CMD write accepted in cycle N latches the walk bounds.
//   - State is RUN from N+1.
// - Walk bounds:
//   - PLOT: (X,Y), 1x1.
//   - FILL: x0=X, y0=Y, x1=min(X+W, RESOLUTION_W), y1=min(Y+H, RESOLUTION_H), exclusive.
//     - Compute sums 9 bits wide; no wrap.
//   - CLEAR: (0,0) to (RESOLUTION_W, RESOLUTION_H) using COL.
// - Clipping: PLOT with X>=RESOLUTION_W or Y>=RESOLUTION_H produces no write.
//   - FILL with an empty clipped box (W=0, H=0, or origin off-screen) produces no write.
// - RUN emits WRITE=1 every cycle with X_POS/Y_POS/COLOR valid in the same cycle.
//   - Raster order: x increments first; at x1-1, x returns to x0 and y increments.
// - Timing: first WRITE at N+1; last pixel at N+P (P = clipped pixel count).
//   - BUSY=1 over cycles N+1..N+P. BUSY=0 and WRITE=0 at N+P+1.
// - Empty command (P=0): BUSY=1 for cycle N+1 only, WRITE never asserted.
// - CLEAR takes 30000 cycles at default parameters.
// - RESET mid-command: aborts at the next edge. WRITE=0 and BUSY=0 the following cycle. No partial retry.
// - Back-to-back: a CMD write at cycle N+P+1 (first non-busy cycle) is accepted.
// STRUCTURE
// - Shared package herring_gpu_pkg holds:
//   - RESOLUTION_W/H and COLOR_DEPTH defaults
//   - register address localparams (REG_X..REG_CMD)
//   - command codes (CMD_PLOT, CMD_FILL, CMD_CLEAR)
//   - state enum (ST_IDLE, ST_RUN)
// - One natural sub-module: raster_walker.
//   - Loads x0/y0/x1/y1.
//   - Outputs the current x,y plus a valid and a last flag.
//   - Steps one pixel per cycle.
// - Top level holds the register file, command decode/clip and the output registers.
// TESTING
// - Reset, then read all addresses -> DATA_OUT=0, BUSY=0, WRITE=0.
// - X=10, Y=20, COL=3'b010, CMD=PLOT at N -> single WRITE at N+1 at (10,20) colour 2; BUSY low at N+2.
// - X=198, Y=148, W=5, H=5, COL=1, FILL -> exactly 4 writes.
//   - Order: (198,148), (199,148), (198,149), (199,149) on consecutive cycles.
// - FILL with W=0; PLOT at (200,0) -> BUSY pulses 1 cycle, zero WRITEs.
// - CLEAR with COL=7 -> 30000 consecutive WRITEs, last at (199,149); DATA_OUT(addr 5)=1 throughout.
//   - Register writes issued mid-CLEAR do not change X/Y/COL readback.
// - RESET asserted at the 100th cycle of CLEAR -> WRITE=0, BUSY=0 next cycle; registers read 0.

Source files
------------

// File: rtl/herring_gpu_pkg.sv
// herring_gpu_pkg: shared parameters, register map, command codes and states for the draw engine
package herring_gpu_pkg;
    localparam int DEF_RES_W = 200;
    localparam int DEF_RES_H = 150;
    localparam int DEF_COLOR_DEPTH = 3;
    localparam logic [2:0] REG_X = 3'd0;
    localparam logic [2:0] REG_Y = 3'd1;
    localparam logic [2:0] REG_COL = 3'd2;
    localparam logic [2:0] REG_W = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_CMD = 3'd5;
    localparam logic [7:0] CMD_PLOT = 8'd0;
    localparam logic [7:0] CMD_FILL = 8'd1;
    localparam logic [7:0] CMD_CLEAR = 8'd2;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    function automatic logic [8:0] clip_end(logic [8:0] sum, logic [8:0] lim);
        return sum > lim ? lim : sum;
    endfunction
endpackage

// File: rtl/gpu_draw_engine_if.sv
// gpu_draw_engine_if: 6502 register bus plus framebuffer write port of the draw engine
interface gpu_draw_engine_if #(
    parameter int COLOR_DEPTH = herring_gpu_pkg::DEF_COLOR_DEPTH
);
    logic [2:0] ADDR;
    logic [7:0] DATA_IN;
    logic WE;
    logic [7:0] DATA_OUT;
    logic [7:0] X_POS;
    logic [7:0] Y_POS;
    logic [COLOR_DEPTH-1:0] COLOR;
    logic WRITE;
    logic BUSY;
    modport master (
        output ADDR, DATA_IN, WE,
        input DATA_OUT, X_POS, Y_POS, COLOR, WRITE, BUSY
    );
    modport slave (
        input ADDR, DATA_IN, WE,
        output DATA_OUT, X_POS, Y_POS, COLOR, WRITE, BUSY
    );
endinterface

// File: rtl/raster_walker.sv
// raster_walker: steps x-first through an exclusive box [x0,x1)x[y0,y1), one pixel per cycle
module raster_walker (
    input logic clk,
    input logic rst,
    input logic load,
    input logic [7:0] x0,
    input logic [7:0] y0,
    input logic [8:0] x1,
    input logic [8:0] y1,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic valid,
    output logic last
);
    logic [7:0] bx0;
    logic [8:0] bx1, by1;
    logic row_end;
    always_comb begin
        row_end = {1'b0, x} == bx1 - 9'd1;
        last = valid && row_end && {1'b0, y} == by1 - 9'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
            bx0 <= '0;
            bx1 <= '0;
            by1 <= '0;
            valid <= 1'b0;
        end else if (load) begin
            x <= x0;
            y <= y0;
            bx0 <= x0;
            bx1 <= x1;
            by1 <= y1;
            valid <= {1'b0, x0} < x1 && {1'b0, y0} < y1;
        end else if (valid) begin
            if (last) valid <= 1'b0;
            else if (row_end) begin
                x <= bx0;
                y <= y + 8'd1;
            end else x <= x + 8'd1;
        end
    end
endmodule

// File: rtl/gpu_draw_engine.sv
// gpu_draw_engine: CPU-loaded register file that turns plot/fill/clear commands
// into a clipped raster of framebuffer pixel writes.
module gpu_draw_engine
    import herring_gpu_pkg::*;
#(
    parameter int RESOLUTION_W = DEF_RES_W,
    parameter int RESOLUTION_H = DEF_RES_H,
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH
) (
    input logic PIXEL_CLOCK,
    input logic RESET,
    gpu_draw_engine_if.slave bus
);
    localparam logic [8:0] LIM_X = 9'(RESOLUTION_W);
    localparam logic [8:0] LIM_Y = 9'(RESOLUTION_H);
    logic [7:0] reg_x, reg_y, reg_w, reg_h;
    logic [COLOR_DEPTH-1:0] reg_col, draw_col;
    state_t state, state_n;
    logic accept, cmd_go, is_plot, is_clear, walk_valid, walk_last;
    logic [7:0] org_x, org_y, walk_x, walk_y;
    logic [8:0] ext_x, ext_y, end_x, end_y;
    // Every command is reduced to an origin plus extent, clipped to the screen edge.
    always_comb begin
        accept = bus.WE && state == ST_IDLE;
        is_plot = bus.DATA_IN == CMD_PLOT;
        is_clear = bus.DATA_IN == CMD_CLEAR;
        cmd_go = accept && bus.ADDR == REG_CMD && (is_plot || is_clear || bus.DATA_IN == CMD_FILL);
        org_x = is_clear ? 8'd0 : reg_x;
        org_y = is_clear ? 8'd0 : reg_y;
        ext_x = is_clear ? LIM_X : is_plot ? 9'd1 : {1'b0, reg_w};
        ext_y = is_clear ? LIM_Y : is_plot ? 9'd1 : {1'b0, reg_h};
        end_x = clip_end({1'b0, org_x} + ext_x, LIM_X);
        end_y = clip_end({1'b0, org_y} + ext_y, LIM_Y);
    end
    always_ff @(posedge PIXEL_CLOCK) begin
        if (RESET) begin
            reg_x <= '0;
            reg_y <= '0;
            reg_w <= '0;
            reg_h <= '0;
            reg_col <= '0;
            draw_col <= '0;
        end else if (accept) begin
            if (bus.ADDR == REG_X) reg_x <= bus.DATA_IN;
            if (bus.ADDR == REG_Y) reg_y <= bus.DATA_IN;
            if (bus.ADDR == REG_COL) reg_col <= bus.DATA_IN[COLOR_DEPTH-1:0];
            if (bus.ADDR == REG_W) reg_w <= bus.DATA_IN;
            if (bus.ADDR == REG_H) reg_h <= bus.DATA_IN;
            if (cmd_go) draw_col <= reg_col;
        end
    end
    always_ff @(posedge PIXEL_CLOCK) state <= RESET ? ST_IDLE : state_n;
    // An empty box still spends one RUN cycle, so BUSY always pulses.
    always_comb begin
        state_n = state;
        if (state == ST_IDLE && cmd_go) state_n = ST_RUN;
        if (state == ST_RUN && (!walk_valid || walk_last)) state_n = ST_IDLE;
    end
    always_comb begin
        bus.BUSY = state == ST_RUN;
        bus.WRITE = state == ST_RUN && walk_valid;
        bus.X_POS = walk_x;
        bus.Y_POS = walk_y;
        bus.COLOR = draw_col;
    end
    always_comb begin
        case (bus.ADDR)
            REG_X: bus.DATA_OUT = reg_x;
            REG_Y: bus.DATA_OUT = reg_y;
            REG_COL: bus.DATA_OUT = 8'(reg_col);
            REG_W: bus.DATA_OUT = reg_w;
            REG_H: bus.DATA_OUT = reg_h;
            REG_CMD: bus.DATA_OUT = {7'b0, state == ST_RUN};
            default: bus.DATA_OUT = 8'd0;
        endcase
    end
    raster_walker walker (
        .clk(PIXEL_CLOCK),
        .rst(RESET),
        .load(cmd_go),
        .x0(org_x),
        .y0(org_y),
        .x1(end_x),
        .y1(end_y),
        .x(walk_x),
        .y(walk_y),
        .valid(walk_valid),
        .last(walk_last)
    );
endmodule

// File: tb/tb_gpu_draw_engine.sv
// tb_gpu_draw_engine: table, hand-written and random command checks against a pixel-list model
module tb_gpu_draw_engine;
    logic PIXEL_CLOCK = 1'b0;
    logic RESET = 1'b1;
    gpu_draw_engine_if #(.COLOR_DEPTH(3)) bus();
    gpu_draw_engine dut (
        .PIXEL_CLOCK(PIXEL_CLOCK),
        .RESET(RESET),
        .bus(bus)
    );
    always #5 PIXEL_CLOCK = ~PIXEL_CLOCK;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int col;
        int cmd;
        int p;
    } vec_t;

    int total = 0;
    int bad = 0;
    int mreg[5];
    int exp_q[$];
    vec_t vecs[10];

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    // Expected pixels in raster order, from the clipping rules with plain loops.
    function automatic void build(int x, int y, int w, int h, int cmd);
        exp_q.delete();
        if (cmd == 2) begin
            x = 0; y = 0; w = 200; h = 150;
        end
        if (cmd == 0) begin
            w = 1; h = 1;
        end
        for (int j = y; j < y + h && j < 150; j++)
            for (int i = x; i < x + w && i < 200; i++)
                exp_q.push_back(i * 256 + j);
    endfunction

    task automatic tick();
        @(posedge PIXEL_CLOCK);
        #1;
    endtask

    task automatic wr(int a, int d);
        bus.ADDR = 3'(a);
        bus.DATA_IN = 8'(d);
        bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0;
        if (a < 5) mreg[a] = (a == 2) ? (d & 7) : (d & 255);
    endtask

    task automatic check_regs(string tag);
        for (int a = 0; a < 8; a++) begin
            bus.ADDR = 3'(a);
            #1;
            chk($sformatf("%s rd%0d", tag, a), int'(bus.DATA_OUT), a < 5 ? mreg[a % 5] : 0);
        end
    endtask

    task automatic issue_cmd(int cmd, bit poke, output int got);
        int nw, nbad, nbusy, nrd, p, col;
        build(mreg[0], mreg[1], mreg[3], mreg[4], cmd);
        col = mreg[2];
        p = exp_q.size();
        got = 0;
        wr(5, cmd);
        if (cmd > 2) begin
            chk("ignored cmd busy", int'(bus.BUSY), 0);
            chk("ignored cmd write", int'(bus.WRITE), 0);
            return;
        end
        nw = 0; nbad = 0; nbusy = 0; nrd = 0;
        for (int c = 0; c < p + 4; c++) begin
            if (!bus.BUSY) break;
            nbusy++;
            if (bus.WRITE) begin
                if (nw != c || nw >= p || int'(bus.X_POS) * 256 + int'(bus.Y_POS) != exp_q[nw]
                    || int'(bus.COLOR) != col) begin
                    if (nbad == 0)
                        $display("first bad pixel at cycle %0d: (%0d,%0d) col %0d", c, bus.X_POS, bus.Y_POS, bus.COLOR);
                    nbad++;
                end
                nw++;
            end
            bus.ADDR = 3'd5;
            bus.WE = 1'b0;
            if (poke && c == 500) begin bus.ADDR = 3'd0; bus.DATA_IN = 8'd55; bus.WE = 1'b1; end
            if (poke && c == 700) begin bus.ADDR = 3'd2; bus.DATA_IN = 8'd3; bus.WE = 1'b1; end
            if (poke && c == 900) begin bus.ADDR = 3'd5; bus.DATA_IN = 8'd1; bus.WE = 1'b1; end
            #1;
            if (bus.ADDR == 3'd5 && bus.DATA_OUT != 8'd1) nrd++;
            tick();
        end
        bus.WE = 1'b0;
        got = nw;
        chk($sformatf("cmd%0d write count", cmd), nw, p);
        chk($sformatf("cmd%0d pixel errors", cmd), nbad, 0);
        chk($sformatf("cmd%0d busy cycles", cmd), nbusy, p > 0 ? p : 1);
        chk($sformatf("cmd%0d write after end", cmd), int'(bus.WRITE), 0);
        chk($sformatf("cmd%0d busy readback errors", cmd), nrd, 0);
    endtask

    task automatic do_cmd(int x, int y, int w, int h, int col, int cmd, output int got);
        wr(0, x); wr(1, y); wr(2, col); wr(3, w); wr(4, h);
        issue_cmd(cmd, 1'b0, got);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        vecs = '{
            '{10, 20, 0, 0, 2, 0, 1},
            '{198, 148, 5, 5, 1, 1, 4},
            '{5, 5, 0, 3, 4, 1, 0},
            '{200, 0, 0, 0, 6, 0, 0},
            '{0, 0, 3, 2, 5, 1, 6},
            '{195, 10, 10, 1, 3, 1, 5},
            '{10, 149, 2, 4, 7, 1, 2},
            '{199, 149, 0, 0, 7, 0, 1},
            '{0, 150, 5, 5, 1, 1, 0},
            '{255, 255, 255, 255, 7, 1, 0}
        };
        for (int i = 0; i < 5; i++) mreg[i] = 0;
        bus.ADDR = 3'd0; bus.DATA_IN = 8'd0; bus.WE = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        chk("reset busy", int'(bus.BUSY), 0);
        chk("reset write", int'(bus.WRITE), 0);
        chk("reset x_pos", int'(bus.X_POS), 0);
        chk("reset y_pos", int'(bus.Y_POS), 0);
        chk("reset color", int'(bus.COLOR), 0);
        check_regs("reset");

        foreach (vecs[i]) begin
            do_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].col, vecs[i].cmd, got);
            chk($sformatf("vec%0d pixel total", i), got, vecs[i].p);
            if (i == 1) check_regs("after fill");
        end
        wr(5, 3);
        issue_cmd(3, 1'b0, got);

        do_cmd(3, 4, 2, 2, 5, 0, got);
        issue_cmd(1, 1'b0, got);
        chk("back-to-back fill total", got, 4);

        for (int i = 0; i < 40; i++) begin
            int c;
            c = $urandom_range(0, 3);
            if (c == 2) c = 1;
            do_cmd($urandom_range(0, 210), $urandom_range(0, 160), $urandom_range(0, 12),
                   $urandom_range(0, 12), $urandom_range(0, 255), c, got);
        end

        wr(0, 9); wr(1, 8); wr(2, 7);
        issue_cmd(2, 1'b1, got);
        chk("clear total", got, 30000);
        check_regs("after clear");

        wr(5, 2);
        repeat (99) tick();
        chk("clear busy before reset", int'(bus.BUSY), 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("abort busy", int'(bus.BUSY), 0);
        chk("abort write", int'(bus.WRITE), 0);
        for (int i = 0; i < 5; i++) mreg[i] = 0;
        check_regs("after abort");
        repeat (3) tick();
        chk("no retry busy", int'(bus.BUSY), 0);
        do_cmd(1, 1, 0, 0, 4, 0, got);
        chk("plot after abort", got, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
